// File: rtl/fifo_1w_drain_pkg.sv
// fifo_1w_drain_pkg: shared state encodings, empty-element fill bit and occupancy helper
package fifo_1w_drain_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Replicated to element width to form the value shown when nothing is buffered
    localparam logic EMPTY_BIT = 1'b1;

    function automatic logic [1:0] occ_after(input logic [1:0] occ, input logic push, input logic pop);
        return occ + {1'b0, push} - {1'b0, pop};
    endfunction

endpackage

// File: rtl/fifo_skid2.sv
// fifo_skid2: two-entry in-order buffer between the FIFO pop side and the downstream handshake
module fifo_skid2 import fifo_1w_drain_pkg::*; #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_val,
    input  logic [W-1:0] in_data,
    output logic         out_val,
    output logic [W-1:0] out_data,
    input  logic         out_rdy,
    output logic [1:0]   occ
);

    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   occ_q, occ_d;
    logic         take;

    assign take     = out_val & out_rdy;
    assign out_val  = occ_q != 2'd0;
    assign out_data = out_val ? e0_q : {W{EMPTY_BIT}};
    assign occ      = occ_q;

    // Shift the head out on transfer, then append the incoming element behind whatever survives
    always_comb begin
        occ_d = occ_after(occ_q, in_val, take);
        e0_d  = take ? e1_q : e0_q;
        e1_d  = e1_q;
        if (in_val) begin
            if (occ_d == 2'd1) e0_d = in_data;
            else               e1_d = in_data;
        end
    end

    // Buffer registers; reset empties the buffer and drops its contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= 2'd0;
            e0_q  <= {W{EMPTY_BIT}};
            e1_q  <= {W{EMPTY_BIT}};
        end else begin
            occ_q <= occ_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

endmodule

// File: rtl/fifo_1w_drain.sv
// fifo_1w_drain: drains a commanded number of elements from an FWFT FIFO into a ready/valid stream
module fifo_1w_drain import fifo_1w_drain_pkg::*; #(
    parameter int FIFO_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_val,
    input  logic [CNT_WIDTH-1:0]  cmd_cnt,
    output logic                  cmd_rdy,
    input  logic                  abort,
    input  logic                  fifo_data_avail,
    input  logic [FIFO_WIDTH-1:0] fifo_r_data,
    output logic                  fifo_r_val,
    output logic                  out_val,
    output logic [FIFO_WIDTH-1:0] out_data,
    input  logic                  out_rdy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  done_cnt
);

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] remaining_q, remaining_d, popped_q, popped_d;
    logic [1:0]           buf_occ;
    logic                 pop;

    // Pops never look at out_rdy; the buffer-space term alone provides backpressure
    assign pop        = (state_q == ST_RUN) & fifo_data_avail & (remaining_q != '0) & (buf_occ < 2'd2) & ~abort;
    assign fifo_r_val = pop;
    assign cmd_rdy    = state_q == ST_IDLE;
    assign done       = state_q == ST_DONE;
    assign done_cnt   = done ? popped_q : '0;

    fifo_skid2 #(.W(FIFO_WIDTH)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_val   (pop),
        .in_data  (fifo_r_data),
        .out_val  (out_val),
        .out_data (out_data),
        .out_rdy  (out_rdy),
        .occ      (buf_occ)
    );

    // Burst sequencing: count pops in RUN, wait for the buffer to empty in FLUSH, pulse DONE once
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        popped_d    = popped_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_val) begin
                    remaining_d = cmd_cnt;
                    popped_d    = '0;
                    state_d     = (cmd_cnt == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                remaining_d = remaining_q - {{(CNT_WIDTH-1){1'b0}}, pop};
                popped_d    = popped_q + {{(CNT_WIDTH-1){1'b0}}, pop};
                state_d     = (abort || remaining_d == '0) ? ST_FLUSH : ST_RUN;
            end
            ST_FLUSH: state_d = (occ_after(buf_occ, 1'b0, out_val & out_rdy) == 2'd0) ? ST_DONE : ST_FLUSH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Control registers; reset abandons any burst in flight without a completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            popped_q    <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            popped_q    <= popped_d;
        end
    end

endmodule
